// File: rtl/bus_if_pkg.sv
// Shared definitions for the cross_bar slave bus: bus widths, cmd encoding
// and the bus_slave_mem FSM state type.
package bus_if_pkg;

   localparam int unsigned AW        = 4;
   localparam int unsigned DW        = 8;
   // addr[AW-1] selects the slave, so each slave sees half the address space.
   localparam int unsigned MEM_WORDS = 2 ** (AW - 1);

   localparam logic CMD_WR = 1'b1;
   localparam logic CMD_RD = 1'b0;

   typedef enum logic [1:0] {
      StIdle,
      StAckWait,
      StRdWait,
      StResp
   } bus_slave_mem_state_t;

endpackage

// File: rtl/bus_if.sv
// Request/acknowledge bus between cross_bar and its slaves.
interface bus_if;

   logic                      req;
   logic                      cmd;
   logic [bus_if_pkg::AW-1:0] addr;
   logic [bus_if_pkg::DW-1:0] wdata;
   logic                      ack;
   logic                      resp;
   logic [bus_if_pkg::DW-1:0] rdata;

   modport master (output req, cmd, addr, wdata, input ack, resp, rdata);
   modport slave  (input req, cmd, addr, wdata, output ack, resp, rdata);

endinterface

// File: rtl/bus_slave_mem_delay.sv
// Loadable 4-bit down-counter; done is high while the count is zero.
module bus_slave_mem_delay (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] value,
   output logic       done
);

   logic [3:0] cnt_q;

   // Load wins over counting; the count parks at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= value;
      end else if (cnt_q != 4'd0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/bus_slave_mem.sv
// Memory-backed bus slave terminating one cross_bar slave port.
// Optional feature macro: BUS_SLAVE_MEM_STATS_EN adds saturating write/read
// transaction counters (wr_cnt, rd_cnt).
module bus_slave_mem
   import bus_if_pkg::*;
#(
   parameter int unsigned   ACK_LATENCY = 1,
   parameter int unsigned   RD_LATENCY  = 2,
   parameter logic [DW-1:0] MEM_INIT    = '0
) (
   input  logic        clk,
   input  logic        reset,
   bus_if.slave        bus,
`ifdef BUS_SLAVE_MEM_STATS_EN
   output logic [15:0] wr_cnt,
   output logic [15:0] rd_cnt,
`endif
   output logic        busy
);

   localparam logic [3:0] AckLoad = 4'(ACK_LATENCY - 1);
   localparam logic [3:0] RdLoad  = 4'(RD_LATENCY - 1);

   bus_slave_mem_state_t state_q;
   logic                 cmd_q;
   logic [AW-2:0]        addr_q;
   logic [DW-1:0]        wdata_q;
   logic [DW-1:0]        rdata_q;
   logic                 ack_q;
   logic                 resp_q;
   logic [DW-1:0]        mem_q [MEM_WORDS];

   logic       start;
   logic       ack_fire;
   logic       wr_fire;
   logic       resp_fire;
   logic       dly_load;
   logic [3:0] dly_value;
   logic       dly_done;
   logic       unused_sel;

   // Slave-select bit is decoded upstream in cross_bar.
   assign unused_sel = bus.addr[AW-1];

   // Transaction events and delay-counter control.
   always_comb begin
      start     = (state_q == StIdle) && bus.req;
      ack_fire  = (state_q == StAckWait) && dly_done;
      wr_fire   = ack_fire && (cmd_q == CMD_WR);
      resp_fire = (state_q == StRdWait) && dly_done;
      dly_load  = start || (ack_fire && (cmd_q == CMD_RD));
      dly_value = start ? AckLoad : RdLoad;
   end

   bus_slave_mem_delay u_delay (
      .clk   (clk),
      .reset (reset),
      .load  (dly_load),
      .value (dly_value),
      .done  (dly_done)
   );

   // FSM, request latch, memory and registered bus outputs.
   // The ack and resp pulses are registered on the edge that returns to
   // IDLE, so a held req starts the next transaction one cycle later and
   // StResp is never occupied.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cmd_q   <= CMD_RD;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         resp_q  <= 1'b0;
         for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem_q[i] <= MEM_INIT;
         end
      end else begin
         ack_q  <= 1'b0;
         resp_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.req) begin
                  cmd_q   <= bus.cmd;
                  addr_q  <= bus.addr[AW-2:0];
                  wdata_q <= bus.wdata;
                  state_q <= StAckWait;
               end
            end
            StAckWait: begin
               if (dly_done) begin
                  ack_q <= 1'b1;
                  if (cmd_q == CMD_WR) begin
                     mem_q[addr_q] <= wdata_q;
                     state_q       <= StIdle;
                  end else begin
                     rdata_q <= mem_q[addr_q];
                     state_q <= StRdWait;
                  end
               end
            end
            StRdWait: begin
               if (dly_done) begin
                  resp_q  <= 1'b1;
                  state_q <= StIdle;
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.ack   = ack_q;
   assign bus.resp  = resp_q;
   assign bus.rdata = rdata_q;
   assign busy      = (state_q != StIdle);

`ifdef BUS_SLAVE_MEM_STATS_EN
   logic [15:0] wr_cnt_q;
   logic [15:0] rd_cnt_q;

   // Saturating counts of write acks and read responses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         if (wr_fire && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
         end
         if (resp_fire && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
         end
      end
   end

   assign wr_cnt = wr_cnt_q;
   assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_bus_slave_mem.sv
// Self-checking bench for bus_slave_mem: a fast instance (1/2 latencies) and
// a slow instance (15/15) against an array model of the memory.
module tb_bus_slave_mem;
   import bus_if_pkg::*;

   localparam int          LA   = 1;
   localparam int          RA   = 2;
   localparam int          LX   = 15;
   localparam int          RX   = 15;
   localparam logic [DW-1:0] INIT = 8'hA5;

   logic clk = 1'b0;
   logic rst_n;
   logic busy_a;
   logic busy_x;

   bus_if bus_a ();
   bus_if bus_x ();

`ifdef BUS_SLAVE_MEM_STATS_EN
   logic [15:0] wr_cnt_a, rd_cnt_a, wr_cnt_x, rd_cnt_x;
`endif

   bus_slave_mem #(.ACK_LATENCY(LA), .RD_LATENCY(RA), .MEM_INIT(INIT)) dut_a (
      .clk    (clk),
      .reset  (rst_n),
      .bus    (bus_a),
`ifdef BUS_SLAVE_MEM_STATS_EN
      .wr_cnt (wr_cnt_a),
      .rd_cnt (rd_cnt_a),
`endif
      .busy   (busy_a)
   );

   bus_slave_mem #(.ACK_LATENCY(LX), .RD_LATENCY(RX), .MEM_INIT(INIT)) dut_x (
      .clk    (clk),
      .reset  (rst_n),
      .bus    (bus_x),
`ifdef BUS_SLAVE_MEM_STATS_EN
      .wr_cnt (wr_cnt_x),
      .rd_cnt (rd_cnt_x),
`endif
      .busy   (busy_x)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int acks_seen_a = 0;
   int acks_exp_a  = 0;
   int wr_exp [2];
   int rd_exp [2];
   logic [DW-1:0] model [2][MEM_WORDS];

   typedef struct {
      logic          cmd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t tbl [9];

   always @(negedge clk) if (rst_n && bus_a.ack === 1'b1) acks_seen_a++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic drive(input bit sel, input logic req, input logic cmd,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      if (sel) begin
         bus_x.req = req; bus_x.cmd = cmd; bus_x.addr = addr; bus_x.wdata = wdata;
      end else begin
         bus_a.req = req; bus_a.cmd = cmd; bus_a.addr = addr; bus_a.wdata = wdata;
      end
   endtask

   function automatic logic [2:0] outs(input bit sel);
      return sel ? {bus_x.ack, bus_x.resp, busy_x} : {bus_a.ack, bus_a.resp, busy_a};
   endfunction

   function automatic logic [DW-1:0] rdata_of(input bit sel);
      return sel ? bus_x.rdata : bus_a.rdata;
   endfunction

   task automatic scramble(input bit sel, input logic req);
      drive(sel, req, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
   endtask

   // One transaction, entered and left at a negedge. Cycle k follows the
   // sampling edge by k edges: ack at k==L, resp at k==L+R, busy until the
   // pulse that ends the transaction. Inputs are scrambled while busy.
   task automatic txn(input bit sel, input logic cmd, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input bit hold, input string tag);
      int l;
      int r;
      int dur;
      logic [2:0] exp;
      logic [DW-1:0] exp_rd;
      logic [DW-1:0] held;
      l      = sel ? LX : LA;
      r      = sel ? RX : RA;
      dur    = (cmd == CMD_WR) ? l + 1 : l + r + 1;
      held   = rdata_of(sel);
      exp_rd = model[sel][addr[AW-2:0]];
      drive(sel, 1'b1, cmd, addr, wdata);
      @(posedge clk);
      for (int k = 0; k < dur; k++) begin
         @(negedge clk);
         exp[2] = (k == l);
         exp[1] = (cmd == CMD_RD) && (k == l + r);
         exp[0] = (cmd == CMD_WR) ? (k < l) : (k < l + r);
         check({tag, " ack/resp/busy"}, 32'(outs(sel)), 32'(exp));
         if (cmd == CMD_RD && k == l + r) check({tag, " rdata"}, 32'(rdata_of(sel)), 32'(exp_rd));
         if (cmd == CMD_WR && k == l) check({tag, " rdata held"}, 32'(rdata_of(sel)), 32'(held));
         if (k < dur - 1) scramble(sel, hold);
      end
      if (cmd == CMD_WR) begin
         model[sel][addr[AW-2:0]] = wdata;
         wr_exp[sel]++;
      end else begin
         rd_exp[sel]++;
      end
      if (!sel) acks_exp_a++;
      if (!hold) scramble(sel, 1'b0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
         model[0][i] = INIT;
         model[1][i] = INIT;
      end
      wr_exp[0] = 0; wr_exp[1] = 0; rd_exp[0] = 0; rd_exp[1] = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      drive(0, 1'b0, CMD_RD, '0, '0);
      drive(1, 1'b0, CMD_RD, '0, '0);
      model_reset();

      tbl[0] = '{CMD_WR, 4'd5,  8'h3C, 8'h00};
      tbl[1] = '{CMD_RD, 4'd5,  8'h00, 8'h3C};
      tbl[2] = '{CMD_WR, 4'd0,  8'h01, 8'h00};
      tbl[3] = '{CMD_WR, 4'd7,  8'hFF, 8'h00};
      tbl[4] = '{CMD_RD, 4'd0,  8'h00, 8'h01};
      tbl[5] = '{CMD_RD, 4'd7,  8'h00, 8'hFF};
      tbl[6] = '{CMD_RD, 4'd1,  8'h00, 8'hA5};
      tbl[7] = '{CMD_WR, 4'd13, 8'h99, 8'h00};
      tbl[8] = '{CMD_RD, 4'd5,  8'h00, 8'h99};

      // Reset defaults, checked while reset is still held.
      repeat (2) @(negedge clk);
      check("reset a outs+rdata", 32'({outs(0), rdata_of(0)}), 32'd0);
      check("reset x outs+rdata", 32'({outs(1), rdata_of(1)}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      txn(0, CMD_RD, 4'd3, 8'h00, 0, "init read a3");

      // Table-driven vectors; table rdata checked independently of the model.
      for (int i = 0; i < 9; i++) begin
         txn(0, tbl[i].cmd, tbl[i].addr, tbl[i].wdata, 0, $sformatf("vec%0d", i));
         if (tbl[i].cmd == CMD_RD) check($sformatf("vec%0d table rdata", i),
                                         32'(bus_a.rdata), 32'(tbl[i].exp_rdata));
         @(negedge clk);
      end

      // Inputs change while busy: the latched write lands at addr 6.
      txn(0, CMD_WR, 4'd6, 8'h5A, 0, "busy change wr");
      txn(0, CMD_RD, 4'd6, 8'h00, 0, "busy change rd");
      check("busy change rdata const", 32'(bus_a.rdata), 32'h5A);

      // Back-to-back, req held high, write then read of the same address.
      for (int i = 0; i < 8; i++) begin
         txn(0, (i % 2 == 0) ? CMD_WR : CMD_RD, AW'(i / 2 + 1), DW'(8'h10 + i), 1, "b2b");
      end
      scramble(0, 1'b0);
      @(negedge clk);
      check("b2b ack count", 32'(acks_seen_a), 32'(acks_exp_a));

      // Randomized traffic against the model.
      for (int i = 0; i < 40; i++) begin
         txn(0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
             bit'($urandom_range(0, 1)), "rand");
      end
      scramble(0, 1'b0);
      @(negedge clk);

      // Latency extremes on the slow instance.
      txn(1, CMD_WR, 4'd2, 8'h77, 0, "ext wr");
      txn(1, CMD_RD, 4'd2, 8'h00, 0, "ext rd");
      txn(1, CMD_RD, 4'd9, 8'h00, 0, "ext rd init");

`ifdef BUS_SLAVE_MEM_STATS_EN
      check("stats wr a", 32'(wr_cnt_a), 32'(wr_exp[0]));
      check("stats rd a", 32'(rd_cnt_a), 32'(rd_exp[0]));
      check("stats wr x", 32'(wr_cnt_x), 32'(wr_exp[1]));
      check("stats rd x", 32'(rd_cnt_x), 32'(rd_exp[1]));
`endif

      // Reset during RD_WAIT: outputs drop at once, no resp afterwards.
      drive(0, 1'b1, CMD_RD, 4'd4, 8'h00);
      @(posedge clk);
      @(negedge clk);
      scramble(0, 1'b0);
      @(negedge clk);
      check("mid-reset ack cycle", 32'(outs(0)), 32'b101);
      acks_exp_a++;
      @(negedge clk);
      check("mid-reset rd_wait", 32'(outs(0)), 32'b001);
      #2 rst_n = 1'b0;
      #1 check("mid-reset async outs+rdata", 32'({outs(0), rdata_of(0)}), 32'd0);
`ifdef BUS_SLAVE_MEM_STATS_EN
      check("mid-reset rd_cnt", 32'(rd_cnt_a), 32'd0);
      check("mid-reset wr_cnt", 32'(wr_cnt_a), 32'd0);
`endif
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post-reset quiet", 32'(outs(0)), 32'd0);
      end
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
         txn(0, CMD_RD, AW'(i), 8'h00, 0, "post-reset init");
      end
      check("total ack count", 32'(acks_seen_a), 32'(acks_exp_a));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
